// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory: instruction field layout,
// opcodes, controller states and the default program image.
package imem_pkg;

  localparam int OPC_HI = 13;
  localparam int OPC_LO = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 8;
  localparam int RS2_HI = 7;
  localparam int RS2_LO = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 4;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OPC_SUB  = 4'b0010;
  localparam logic [3:0] OPC_ADDI = 4'b0110;
  localparam logic [3:0] OPC_ORI  = 4'b1000;
  localparam logic [3:0] OPC_BNE  = 4'b1011;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PROG  = 2'd2
  } state_e;

  // Boot program; every word not listed is a NOP.
  function automatic logic [15:0] default_word(input int idx);
    case (idx)
      0:       return 16'h1815;
      1:       return 16'h202A;
      2:       return 16'h09B0;
      3:       return 16'h2EC0;
      default: return NOP_WORD;
    endcase
  endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port synchronous RAM with power-up image. Contents survive reset;
// only the read register is cleared. Out-of-range reads return zero.
module imem_array
  import imem_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int DEPTH        = 16,
  parameter int LOAD_DEFAULT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_re,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  function automatic logic [DEPTH-1:0][DATA_W-1:0] f_init();
    logic [DEPTH-1:0][DATA_W-1:0] img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = (LOAD_DEFAULT != 0) ? DATA_W'(default_word(i)) : '0;
    end
    return img;
  endfunction

  logic [DEPTH-1:0][DATA_W-1:0] r_mem = f_init();
  logic [DATA_W-1:0]            r_rdata;
  logic                         w_in_range;

  assign w_in_range = ({1'b0, i_addr} < DEPTH_L);

  always_ff @(posedge i_clk) begin
    if (i_we && w_in_range) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= w_in_range ? r_mem[i_addr] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_prog_fetch.sv
// Instruction memory with a registered, handshaked fetch port and a run-time
// programming port; the RUN/DRAIN/PROG controller keeps the two ports exclusive.
module imem_prog_fetch
  import imem_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int DEPTH        = 16,
  parameter int LOAD_DEFAULT = 1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iFetchReq,
  input  logic [ADDR_W-1:0] iFetchAddr,
  output logic              oFetchRdy,
  output logic              oInstValid,
  output logic [DATA_W-1:0] oInst,
  output logic              oFault,
  input  logic              iInstAck,
  input  logic              iProgEn,
  input  logic              iProgWe,
  input  logic [ADDR_W-1:0] iProgAddr,
  input  logic [DATA_W-1:0] iProgData,
  output logic              oProgRdy,
  output logic              oProgErr
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e              r_state;
  state_e              w_next;
  logic                r_inst_valid;
  logic                r_fault;
  logic                r_prog_rdy;
  logic                r_prog_err;
  logic                w_fetch_rdy;
  logic                w_accept;
  logic                w_in_prog;
  logic                w_prog_in_range;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;

  assign w_in_prog       = (r_state == ST_PROG);
  assign w_fetch_rdy     = (r_state == ST_RUN) && !iProgEn && (!r_inst_valid || iInstAck);
  assign w_accept        = iFetchReq && w_fetch_rdy;
  assign w_prog_in_range = ({1'b0, iProgAddr} < DEPTH_L);
  assign w_we            = w_in_prog && iProgWe && w_prog_in_range;
  // Single RAM port: the programming address only matters while in PROG.
  assign w_addr          = w_in_prog ? iProgAddr : iFetchAddr;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (iProgEn) begin
          w_next = (!r_inst_valid || iInstAck) ? ST_PROG : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!iProgEn) begin
          w_next = ST_RUN;
        end else if (iInstAck) begin
          w_next = ST_PROG;
        end
      end
      ST_PROG: begin
        if (!iProgEn) begin
          w_next = ST_RUN;
        end
      end
      default: w_next = ST_RUN;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state      <= ST_RUN;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_prog_rdy   <= 1'b0;
      r_prog_err   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_prog_rdy <= (w_next == ST_PROG);
      r_prog_err <= w_in_prog && iProgWe && !w_prog_in_range;
      if (w_accept) begin
        r_inst_valid <= 1'b1;
        r_fault      <= ({1'b0, iFetchAddr} >= DEPTH_L);
      end else if (iInstAck) begin
        r_inst_valid <= 1'b0;
      end
    end
  end

  imem_array #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .DEPTH        (DEPTH),
    .LOAD_DEFAULT (LOAD_DEFAULT)
  ) u_array (
    .i_clk   (iClk),
    .i_rst_n (iRst_n),
    .i_re    (w_accept),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (iProgData),
    .o_rdata (oInst)
  );

  assign oFetchRdy  = w_fetch_rdy;
  assign oInstValid = r_inst_valid;
  assign oFault     = r_fault;
  assign oProgRdy   = r_prog_rdy;
  assign oProgErr   = r_prog_err;

endmodule

// File: doc/imem_prog_fetch.md
Name: imem_prog_fetch

Overview:
- Parametrised instruction memory for the hardwired-controller core. It replaces the fixed 16x16 combinational ROM with a registered, handshaked fetch port and a programming port, so that programs can be loaded at run time.
- Sits between the PC/fetch logic and the decoder.
- Memory contents are preloaded with the default image from the package. They are not cleared by reset.

Parameters:
- DATA_W, 16, instruction word width; the 14-bit instruction occupies bits [13:0], and upper bits are zero in the default image.
- ADDR_W, 4, address width of both ports.
- DEPTH, 16, number of implemented words; must be at most 2**ADDR_W.
- LOAD_DEFAULT, 1, 1 = preload the package default image; 0 = preload all zeros.

Ports:
- iClk  in  1  system clock, rising edge.
- iRst_n  in  1  asynchronous reset, active low.
- iFetchReq  in  1  fetch request.
- iFetchAddr  in  ADDR_W  fetch address.
- oFetchRdy  out  1  a fetch is accepted this cycle if iFetchReq=1.
- oInstValid  out  1  oInst holds a fetched word.
- oInst  out  DATA_W  fetched instruction.
- oFault  out  1  qualifies oInst: the fetch address was >= DEPTH.
- iInstAck  in  1  consumer takes oInst this cycle.
- iProgEn  in  1  request programming mode.
- iProgWe  in  1  write strobe, valid only when oProgRdy=1.
- iProgAddr  in  ADDR_W  write address.
- iProgData  in  DATA_W  write data.
- oProgRdy  out  1  block is in programming mode and writes commit.
- oProgErr  out  1  one-cycle pulse: write address was >= DEPTH.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is asynchronous and active-low (iRst_n).
  - Reset values: state=RUN, oInstValid=0, oInst=0, oFault=0, oProgRdy=0, oProgErr=0.
  - Memory array is unaffected by reset.
- Fetch acceptance:
  - oFetchRdy = (state==RUN) && !iProgEn && (!oInstValid || iInstAck). This is combinational.
  - Accept = iFetchReq && oFetchRdy.
- Fetch latency:
  - Exactly 1 cycle. The word read on accept appears on oInst, with oInstValid=1, at the next rising edge.
  - Back-to-back accepts with iInstAck held at 1 give one instruction per cycle.
- Output hold:
  - While oInstValid=1 and iInstAck=0, oInst and oFault hold stable and no new fetch is accepted.
  - On iInstAck=1 with no accept in the same cycle, oInstValid goes to 0 next cycle. oInst keeps its last value.
- Out-of-range fetch:
  - iFetchAddr >= DEPTH returns NOP (all zeros) with oFault=1.
  - An in-range fetch drives oFault=0.
- State machine:
  - RUN:
    - If iProgEn=1 and (oInstValid=0, or iInstAck=1 this cycle) -> PROG.
    - If iProgEn=1 otherwise -> DRAIN.
    - iProgEn has priority over iFetchReq in the same cycle.
  - DRAIN:
    - No fetch accepted; waits for iInstAck=1 -> PROG.
    - If iProgEn drops before the ack -> RUN.
  - PROG:
    - oProgRdy=1 (registered, asserted on entry). oInstValid is held at 0.
    - iProgWe=1 writes iProgData to mem[iProgAddr] at the edge; the word is readable by the first fetch after returning to RUN.
    - iProgEn=0 -> RUN next cycle, with oProgRdy=0 in that same cycle.
- Programming-port rules:
  - Write to an address >= DEPTH is ignored and pulses oProgErr for one cycle.
  - iProgWe outside PROG is ignored, with no error pulse.
- Port exclusion:
  - Read and write never coincide, because the ports are mutually exclusive by state.
  - No read-during-write behaviour needs defining.
- Reset mid-operation:
  - Any state -> RUN; pending output is discarded.
  - Memory keeps words already written.

Decomposition:
- Package imem_pkg:
  - Instruction field positions: OPC [13:10], RS1 [9:8], RS2 [7:6], RD [5:4], IMM [3:0].
  - Opcode constants: SUB=4'b0010, ADDI=4'b0110, ORI=4'b1000, BNE=4'b1011.
  - NOP word = 0.
  - State enum {RUN, DRAIN, PROG}.
  - DEFAULT_IMAGE: word 0=16'h1815, 1=16'h202A, 2=16'h09B0, 3=16'h2EC0, rest 0.
- One natural sub-module: imem_array, a simple single-port synchronous RAM with preload.
- Handshake logic and the FSM stay in the top module.

Test Plan:
1. Reset, then fetch addresses 0..3 back-to-back with iInstAck=1 -> oInst = 1815, 202A, 09B0, 2EC0 (hex) on consecutive cycles, each 1 cycle after its accept, with oFault=0.
2. Fetch addr 2 and hold iInstAck=0 for 3 cycles -> oInst=09B0 stable and oFetchRdy=0. Ack -> oFetchRdy=1 in the same cycle.
3. DEPTH=12: fetch addr 13 -> oInst=0 with oFault=1. Then fetch addr 1 -> oInst=202A with oFault=0.
4. Raise iProgEn while an unacked word is held -> state DRAIN, oProgRdy=0. Ack -> PROG. Write mem[5]=16'h1234, drop iProgEn, fetch addr 5 -> oInst=1234.
5. In PROG, write to addr 14 with DEPTH=12 -> oProgErr pulses for one cycle and memory is unchanged. iProgWe pulsed in RUN -> no write, no error.
6. Assert iRst_n=0 asynchronously mid-fetch (between clock edges) -> oInstValid=0 immediately. After release, fetch addr 5 still returns 1234 (memory persists).
